// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for sram_arbiter.
// slave is the arbiter's view, master is the view of whoever drives the requests and the pins.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 8
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_o;
  logic              sram_data_oe;
  logic [DATA_W-1:0] sram_data_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  logic              busy;
  logic              grant_b;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  sram_data_i,
    output a_ack, a_rdata, b_ack, b_rdata,
    output sram_addr, sram_data_o, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n,
    output busy, grant_b
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output sram_data_i,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  sram_addr, sram_data_o, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  busy, grant_b
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter for the shared cartridge SRAM between requesters A and B, with a
// registered SETUP/STROBE/HOLD strobe sequencer. All SRAM-facing outputs come from flops.
module sram_arbiter #(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ACC_CYCLES = 3
) (
  input logic           clk,
  input logic           reset_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  localparam logic [3:0] AccLast = 4'(ACC_CYCLES);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              last_b_q;
  logic              own_b_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ce_n_q, oe_n_q, we_n_q, data_oe_q;
  logic              a_ack_q, b_ack_q, busy_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that did not own the previous access wins.
  always_comb begin
    pick_b    = bus.b_req && (!bus.a_req || !last_b_q);
    sel_we    = pick_b ? bus.b_we    : bus.a_we;
    sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      own_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.a_req || bus.b_req) begin
            state_q   <= StSetup;
            own_b_q   <= pick_b;
            last_b_q  <= pick_b;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            ce_n_q    <= 1'b0;
            data_oe_q <= sel_we;
            busy_q    <= 1'b1;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          cnt_q   <= 4'd1;
          oe_n_q  <= we_q;
          we_n_q  <= !we_q;
        end
        StStrobe: begin
          if (cnt_q == AccLast) begin
            state_q <= StHold;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            a_ack_q <= !own_b_q;
            b_ack_q <= own_b_q;
            if (!we_q) begin
              if (own_b_q) b_rdata_q <= bus.sram_data_i;
              else         a_rdata_q <= bus.sram_data_i;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StHold: begin
          // Address and write data stay on the pins for hold time; only the enables drop.
          state_q   <= StIdle;
          cnt_q     <= '0;
          ce_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
          a_ack_q   <= 1'b0;
          b_ack_q   <= 1'b0;
          busy_q    <= 1'b0;
          own_b_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sram_addr    = addr_q;
  assign bus.sram_data_o  = wdata_q;
  assign bus.sram_data_oe = data_oe_q;
  assign bus.sram_ce_n    = ce_n_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.a_ack        = a_ack_q;
  assign bus.b_ack        = b_ack_q;
  assign bus.a_rdata      = a_rdata_q;
  assign bus.b_rdata      = b_rdata_q;
  assign bus.busy         = busy_q;
  assign bus.grant_b      = own_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default build plus an ACC_CYCLES=1 build, each with a
// small SRAM model keyed on the low address byte.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(21), .DATA_W(8)) bus ();
  sram_arbiter_if #(.ADDR_W(21), .DATA_W(8)) bus1 ();

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACC_CYCLES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACC_CYCLES(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       pre_en0, pre_en1;
  logic [7:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (pre_en0) mem0[pre_addr] <= pre_data;
    if (!bus.sram_ce_n && !bus.sram_we_n) mem0[bus.sram_addr[7:0]] <= bus.sram_data_o;
  end
  always @(posedge clk) begin
    if (pre_en1) mem1[pre_addr] <= pre_data;
    if (!bus1.sram_ce_n && !bus1.sram_we_n) mem1[bus1.sram_addr[7:0]] <= bus1.sram_data_o;
  end

  // Junk value when not strobed, so a mistimed capture shows up.
  assign bus.sram_data_i  = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem0[bus.sram_addr[7:0]] : 8'hEE;
  assign bus1.sram_data_i = (!bus1.sram_ce_n && !bus1.sram_oe_n) ? mem1[bus1.sram_addr[7:0]]
                                                                 : 8'hEE;

  logic [7:0] vec0, vec1;
  assign vec0 = {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe,
                 bus.a_ack, bus.b_ack, bus.busy, bus.grant_b};
  assign vec1 = {bus1.sram_ce_n, bus1.sram_oe_n, bus1.sram_we_n, bus1.sram_data_oe,
                 bus1.a_ack, bus1.b_ack, bus1.busy, bus1.grant_b};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {ce_n, oe_n, we_n, data_oe, a_ack, b_ack, busy, grant_b} in cycle k after the request.
  function automatic logic [7:0] exp_vec(input int k, input bit we, input bit ob, input int acc);
    if (k == 1) return {1'b0, 1'b1, 1'b1, we, 1'b0, 1'b0, 1'b1, ob};
    if (k >= 2 && k <= 1 + acc) return {1'b0, we, !we, we, 1'b0, 1'b0, 1'b1, ob};
    if (k == 2 + acc) return {1'b0, 1'b1, 1'b1, we, !ob, ob, 1'b1, ob};
    return 8'b1110_0000;
  endfunction

  task automatic preload(input bit sel1, input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    if (sel1) pre_en1 = 1'b1;
    else      pre_en0 = 1'b1;
    @(negedge clk);
    pre_en0 = 1'b0;
    pre_en1 = 1'b0;
  endtask

  // Issue one access on dut at the current negedge (cycle 0) and check cycles 1..6.
  task automatic run_single(input string name, input bit pb, input bit we,
                            input logic [20:0] addr, input logic [7:0] wd,
                            input logic [7:0] ear, input logic [7:0] ebr);
    if (pb) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("%s c%0d strobes", name, k), 32'(vec0), 32'(exp_vec(k, we, pb, 3)));
      if (k <= 5) check($sformatf("%s c%0d addr", name, k), 32'(bus.sram_addr), 32'(addr));
      if (we && k <= 5) check($sformatf("%s c%0d wdata", name, k), 32'(bus.sram_data_o), 32'(wd));
      if (k == 5) begin
        check($sformatf("%s a_rdata", name), 32'(bus.a_rdata), 32'(ear));
        check($sformatf("%s b_rdata", name), 32'(bus.b_rdata), 32'(ebr));
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_done;
    int b_done;
    bit ob;
    reset_n = 1'b0;
    pre_en0 = 1'b0; pre_en1 = 1'b0; pre_addr = '0; pre_data = '0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = '0; bus1.b_wdata = '0;
    repeat (2) @(negedge clk);

    check("reset strobes", 32'(vec0), 32'h0000_00E0);
    check("reset strobes acc1", 32'(vec1), 32'h0000_00E0);
    check("reset sram_addr", 32'(bus.sram_addr), 32'h0);
    check("reset sram_data_o", 32'(bus.sram_data_o), 32'h0);
    check("reset a_rdata", 32'(bus.a_rdata), 32'h0);
    check("reset b_rdata", 32'(bus.b_rdata), 32'h0);
    reset_n = 1'b1;

    // A write, started in the first cycle after reset release.
    run_single("t1 a_write", 1'b0, 1'b1, 21'h1ABCD, 8'h5A, 8'h00, 8'h00);
    check("t1 mem", 32'(mem0[8'hCD]), 32'h5A);

    preload(1'b0, 8'h10, 8'h3C);
    preload(1'b0, 8'h30, 8'hC3);
    preload(1'b1, 8'h10, 8'h5C);

    run_single("t2 b_read", 1'b1, 1'b0, 21'h00010, 8'h00, 8'h00, 8'h3C);

    // Both ports held high for four reads each; last owner was B so A goes first.
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 21'h00010;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 21'h00030;
    a_done = 0;
    b_done = 0;
    for (int i = 0; i < 8; i++) begin
      ob = (i % 2) == 1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        check($sformatf("t3 acc%0d c%0d strobes", i, k), 32'(vec0), 32'(exp_vec(k, 1'b0, ob, 3)));
        if (k == 3)
          check($sformatf("t3 acc%0d addr", i), 32'(bus.sram_addr),
                ob ? 32'h00030 : 32'h00010);
        if (!ob && k == 1) bus.b_addr = 21'h1FFFF;
        if (!ob && k == 4) bus.b_addr = 21'h00030;
        if (k == 5) begin
          if (ob) begin
            check($sformatf("t3 acc%0d b_rdata", i), 32'(bus.b_rdata), 32'hC3);
            b_done++;
            if (b_done == 4) bus.b_req = 0;
          end else begin
            check($sformatf("t3 acc%0d a_rdata", i), 32'(bus.a_rdata), 32'h3C);
            a_done++;
            if (a_done == 4) bus.a_req = 0;
          end
        end
      end
    end

    // Reset during the third cycle of a write drops the access.
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 21'h00040; bus.a_wdata = 8'h77;
    repeat (3) @(negedge clk);
    check("t4 c3 strobes", 32'(vec0), 32'(exp_vec(3, 1'b1, 1'b0, 3)));
    reset_n = 1'b0;
    bus.a_req = 0;
    #1;
    check("t4 async strobes", 32'(vec0), 32'h0000_00E0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("t4 in reset %0d", k), 32'(vec0), 32'h0000_00E0);
    end
    check("t4 a_rdata", 32'(bus.a_rdata), 32'h0);
    check("t4 b_rdata", 32'(bus.b_rdata), 32'h0);
    reset_n = 1'b1;
    run_single("t4 rewrite", 1'b0, 1'b1, 21'h00040, 8'h99, 8'h00, 8'h00);
    check("t4 mem", 32'(mem0[8'h40]), 32'h99);

    // Write through A, read back through B.
    run_single("t6 a_write", 1'b0, 1'b1, 21'h00050, 8'hA5, 8'h00, 8'h00);
    run_single("t6 b_read", 1'b1, 1'b0, 21'h00050, 8'h00, 8'h00, 8'hA5);

    // Single read on the ACC_CYCLES=1 build.
    bus1.b_req = 1; bus1.b_we = 0; bus1.b_addr = 21'h00010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t5 c%0d strobes", k), 32'(vec1), 32'(exp_vec(k, 1'b0, 1'b1, 1)));
      if (k == 3) begin
        check("t5 b_rdata", 32'(bus1.b_rdata), 32'h5C);
        check("t5 a_rdata", 32'(bus1.a_rdata), 32'h0);
        bus1.b_req = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port SRAM access arbiter and timing sequencer for the cartridge SRAM. It shares the single 21-bit-address, 8-bit-data SRAM between requester A (AVR loader path) and requester B (console bus path). It grants the SRAM round-robin and generates the ce_n/oe_n/we_n strobe sequence with programmable strobe width. The block sits between the requester logic and the top-level SRAM pins; the top level owns the sram_data tristate using sram_data_oe.

## Interface

Parameters:
- ADDR_W, 21, SRAM address width
- DATA_W, 8, SRAM data width
- ACC_CYCLES, 3, strobe-active cycles per access; legal range 1..15

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  reset; asynchronous, active-low
- a_req  in  1  requester A access request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_ack  out  1  A completion pulse
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B
- sram_addr  out  ADDR_W  SRAM address
- sram_data_o  out  DATA_W  SRAM write data
- sram_data_oe  out  1  1 = drive sram_data pins with sram_data_o
- sram_data_i  in  DATA_W  SRAM pin data, read side
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active-low
- busy  out  1  access in progress (state != IDLE)
- grant_b  out  1  1 = B owns the current access; 0 in IDLE

## Operation

- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE, no request: remain in IDLE.
- IDLE, a request is pending: the arbiter
  - selects the owner;
  - latches the owner's addr, we and wdata into internal registers;
  - moves to SETUP.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the port not granted last wins.
  - last_owner resets to B, so the first tie goes to A.
- SETUP (1 cycle): sram_ce_n=0, sram_addr=latched address; oe_n=1, we_n=1; sram_data_oe=1 for writes only.
- STROBE (ACC_CYCLES cycles, counted by a 4-bit counter):
  - ce_n=0.
  - Read: oe_n=0.
  - Write: we_n=0, data driven.
  - On a read, the last STROBE cycle captures sram_data_i into the owner's rdata register.
- HOLD (1 cycle):
  - oe_n=1, we_n=1; ce_n stays 0.
  - Address and write data stay driven (hold time).
  - The owner's ack=1 for exactly this cycle.
  - Next state: IDLE unconditionally.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until the cycle ack is seen.
  - req still high in the cycle after ack is a new request.
  - The block latches inputs in IDLE, so later input changes do not affect the access in flight.
- rdata behaviour:
  - Each port's rdata is updated only by that port's reads.
  - The value holds until that port's next read completes.
  - Writes never modify rdata.
- Outputs are registered (FSM-decoded flops); no combinational path from req to the SRAM pins.
- Reset values (async, immediate on reset_n=0):
  - state IDLE, ce_n=oe_n=we_n=1, sram_data_oe=0;
  - sram_addr=0, sram_data_o=0;
  - a_ack=b_ack=0, a_rdata=b_rdata=0;
  - busy=0, grant_b=0, last_owner=B, counter=0.
- Reset mid-access: strobes deassert asynchronously; the access is dropped with no ack; the requester must re-request after reset.

## Timing

- Cycle 0 is the IDLE cycle in which req is sampled high.
- Per access:
  - cycle 1: SETUP
  - cycles 2..1+ACC_CYCLES: STROBE
  - cycle 2+ACC_CYCLES: HOLD, ack=1, rdata valid
  - cycle 3+ACC_CYCLES: IDLE
- Default (ACC_CYCLES=3): ack in cycle 5; a new access can start SETUP at cycle 7. Maximum throughput is one access per ACC_CYCLES+3 cycles.
- Back-to-back with both ports requesting: ownership alternates A, B, A, …; neither port waits more than one access.
- Request arriving during busy: it waits; the next IDLE cycle arbitrates.
- busy is high from SETUP through HOLD inclusive.
- grant_b is valid over the same cycles as busy.
- ACC_CYCLES=1: exactly one STROBE cycle.

## Test plan

- Reset released, a_req=1, a_we=1, a_addr=0x1ABCD, a_wdata=0x5A → SETUP in cycle 1; we_n low cycles 2–4; a_ack in cycle 5 only; sram_addr=0x1ABCD and sram_data_oe=1 from cycle 1 through 5; oe_n stays 1.
- SRAM model preloaded 0x3C at 0x00010, b_req read of 0x00010 → oe_n low cycles 2–4; b_rdata=0x3C at cycle 5; b_ack pulses once; a_rdata unchanged (0).
- a_req and b_req both held high for 4 accesses each → grant order A, B, A, B…; each access 6 cycles; no ack to the non-owner; b_addr change mid-A-access is ignored.
- Reset_n pulled low in cycle 3 of a write → ce_n/we_n/sram_data_oe go inactive immediately; no ack; after release a fresh request completes normally.
- ACC_CYCLES=1 build, single read → ack in cycle 3; oe_n low for exactly one cycle.
- Write 0xA5 via A, then read via B at the same address → b_rdata=0xA5; a_rdata unchanged.
